// File: rtl/hex_text_pkg.sv
// Shared constants and types for the hex text byte loader.
package hex_text_pkg;

  localparam int DEPTH = 512;
  localparam int AW    = 9;

  // ASCII codes of interest to the parser
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_F     = 8'h46;
  localparam logic [7:0] CH_a     = 8'h61;
  localparam logic [7:0] CH_f     = 8'h66;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_COMMA = 8'h2C;

  typedef enum logic [1:0] {CC_HEX, CC_SEP, CC_BAD} char_class_t;

  typedef enum logic {S_HI, S_LO} parse_state_t;

endpackage

// File: rtl/hex_char_classifier.sv
// Combinational ASCII classifier: hex digit, separator or illegal, plus nibble value.
module hex_char_classifier
  import hex_text_pkg::*;
(
  input  logic [7:0]  in_byte,
  output char_class_t cls,
  output logic [3:0]  nib
);

  // Decode the character class and the nibble value of hex digits
  always_comb begin
    cls = CC_BAD;
    nib = 4'h0;
    if (in_byte >= CH_0 && in_byte <= CH_9) begin
      cls = CC_HEX;
      nib = 4'(in_byte - CH_0);
    end else if (in_byte >= CH_A && in_byte <= CH_F) begin
      cls = CC_HEX;
      nib = 4'(in_byte - CH_A + 8'd10);
    end else if (in_byte >= CH_a && in_byte <= CH_f) begin
      cls = CC_HEX;
      nib = 4'(in_byte - CH_a + 8'd10);
    end else if (in_byte == CH_SP || in_byte == CH_TAB || in_byte == CH_CR ||
                 in_byte == CH_LF || in_byte == CH_COMMA) begin
      cls = CC_SEP;
    end
  end

endmodule

// File: rtl/hex_text_byte_loader.sv
// Parses ASCII hex text from the SD file reader into a byte RAM and presents
// one stored byte at a time as two display nibbles, stepped by a key.
//
// Input handshake: in_en, in_done and step are levels; only their rising edges
// act, and each acts in the single cycle where the input is first seen high.
// in_en edges arrive no faster than one every two cycles, so there is no
// backpressure. An in_en edge takes priority over a coincident in_done edge.
module hex_text_byte_loader
  import hex_text_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clear,
  input  logic          in_en,
  input  logic [7:0]    in_byte,
  input  logic          in_done,
  input  logic          step,
  output logic [3:0]    disp_hi,
  output logic [3:0]    disp_lo,
  output logic          disp_valid,
  output logic [AW:0]   byte_count,
  output logic [AW:0]   rd_index,
  output logic          parse_err,
  output logic          overflow,
  output parse_state_t  dbg_state
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

  logic         en_q, done_q, step_q;
  logic         en_rise, done_rise, step_rise;
  char_class_t  cls;
  logic [3:0]   nib;
  parse_state_t state, state_nx;
  logic [3:0]   hi_nib;
  logic         hi_load, commit, err_set;
  logic [7:0]   commit_byte;
  logic         wr_en, step_ok;
  logic [AW:0]  rd_next;
  logic [7:0]   ram [DEPTH];
  logic [7:0]   ram_q;

  assign en_rise   = in_en   & ~en_q;
  assign done_rise = in_done & ~done_q;
  assign step_rise = step    & ~step_q;
  assign dbg_state = state;

  hex_char_classifier u_classifier (
    .in_byte (in_byte),
    .cls     (cls),
    .nib     (nib)
  );

  // Edge-detect history flops
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
      step_q <= 1'b0;
    end else if (clear) begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
      step_q <= 1'b0;
    end else begin
      en_q   <= in_en;
      done_q <= in_done;
      step_q <= step;
    end
  end

  // Parser state register and pending high nibble
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_HI;
      hi_nib <= 4'h0;
    end else if (clear) begin
      state  <= S_HI;
      hi_nib <= 4'h0;
    end else begin
      state <= state_nx;
      if (hi_load) hi_nib <= nib;
    end
  end

  // Parser next state: latch a high nibble, commit a byte, or flag an error
  always_comb begin
    state_nx    = state;
    hi_load     = 1'b0;
    commit      = 1'b0;
    commit_byte = 8'h00;
    err_set     = 1'b0;
    if (en_rise) begin
      case (state)
        S_HI: begin
          case (cls)
            CC_HEX: begin
              hi_load  = 1'b1;
              state_nx = S_LO;
            end
            CC_SEP:  ;
            default: err_set = 1'b1;
          endcase
        end
        S_LO: begin
          state_nx = S_HI;
          case (cls)
            CC_HEX: begin
              commit      = 1'b1;
              commit_byte = {hi_nib, nib};
            end
            CC_SEP: begin
              commit      = 1'b1;
              commit_byte = {4'h0, hi_nib};
            end
            default: err_set = 1'b1;
          endcase
        end
        default: state_nx = S_HI;
      endcase
    end else if (done_rise && state == S_LO) begin
      commit      = 1'b1;
      commit_byte = {4'h0, hi_nib};
      state_nx    = S_HI;
    end
  end

  assign wr_en   = commit && (byte_count != CNT_FULL);
  assign rd_next = rd_index + CNT_ONE;
  assign step_ok = step_rise && (rd_next < byte_count);

  // Simple dual-port byte RAM: write at the fill pointer, read the displayed index
  always_ff @(posedge clk) begin
    if (wr_en) ram[byte_count[AW-1:0]] <= commit_byte;
    ram_q <= ram[rd_index[AW-1:0]];
  end

  // Fill count, sticky flags and readout index
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_count <= '0;
      rd_index   <= '0;
      disp_valid <= 1'b0;
      parse_err  <= 1'b0;
      overflow   <= 1'b0;
    end else if (clear) begin
      byte_count <= '0;
      rd_index   <= '0;
      disp_valid <= 1'b0;
      parse_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en)                 byte_count <= byte_count + CNT_ONE;
      if (commit && !wr_en)      overflow   <= 1'b1;
      if (err_set)               parse_err  <= 1'b1;
      if (step_ok)               rd_index   <= rd_next;
      // ram_q picks up RAM[0] on the same edge that raises disp_valid
      if (!disp_valid && byte_count != '0) disp_valid <= 1'b1;
    end
  end

  // Display is blanked until the first byte has been read out
  always_comb begin
    disp_hi = 4'h0;
    disp_lo = 4'h0;
    if (disp_valid) begin
      disp_hi = ram_q[7:4];
      disp_lo = ram_q[3:0];
    end
  end

endmodule

// File: tb/tb_hex_text_byte_loader.sv
// Randomized and directed bench for hex_text_byte_loader against a
// character-level reference model of the stored file.
module tb_hex_text_byte_loader;
  import hex_text_pkg::*;

  localparam int TB_DEPTH = 512;
  localparam int TB_AW    = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clear = 1'b0;
  logic in_en = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic in_done = 1'b0;
  logic step = 1'b0;
  logic [3:0] disp_hi, disp_lo;
  logic disp_valid, parse_err, overflow;
  logic [TB_AW:0] byte_count, rd_index;
  parse_state_t dbg_state;

  always #5 clk = ~clk;

  hex_text_byte_loader #(.DEPTH(TB_DEPTH), .AW(TB_AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (clear),
    .in_en      (in_en),
    .in_byte    (in_byte),
    .in_done    (in_done),
    .step       (step),
    .disp_hi    (disp_hi),
    .disp_lo    (disp_lo),
    .disp_valid (disp_valid),
    .byte_count (byte_count),
    .rd_index   (rd_index),
    .parse_err  (parse_err),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  int   m_rd;
  bit   m_pend;
  logic [3:0] m_hi;
  bit   m_err, m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_rd = 0; m_pend = 0; m_hi = 4'h0; m_err = 0; m_ovf = 0;
  endtask

  task automatic model_store(input logic [7:0] b);
    if (exp_q.size() == TB_DEPTH) m_ovf = 1;
    else exp_q.push_back(b);
  endtask

  // 0 = hex digit, 1 = separator, 2 = illegal
  function automatic int kind_of(input logic [7:0] c, output logic [3:0] v);
    int x;
    v = 4'h0;
    x = int'(c);
    if (x >= 48 && x <= 57)  begin v = 4'(x - 48); return 0; end
    if (x >= 65 && x <= 70)  begin v = 4'(x - 55); return 0; end
    if (x >= 97 && x <= 102) begin v = 4'(x - 87); return 0; end
    if (x == 32 || x == 9 || x == 13 || x == 10 || x == 44) return 1;
    return 2;
  endfunction

  task automatic model_char(input logic [7:0] c);
    logic [3:0] v;
    int k;
    k = kind_of(c, v);
    if (k == 0) begin
      if (m_pend) begin model_store({m_hi, v}); m_pend = 0; end
      else begin m_hi = v; m_pend = 1; end
    end else if (k == 1) begin
      if (m_pend) model_store({4'h0, m_hi});
      m_pend = 0;
    end else begin
      m_err = 1; m_pend = 0;
    end
  endtask

  task automatic model_done();
    if (m_pend) model_store({4'h0, m_hi});
    m_pend = 0;
  endtask

  task automatic model_step();
    if (m_rd + 1 < exp_q.size()) m_rd++;
  endtask

  task automatic check_state(input string tag);
    logic [7:0] e;
    e = (exp_q.size() != 0) ? exp_q[m_rd] : 8'h00;
    check({tag, "_count"}, 32'(byte_count), exp_q.size());
    check({tag, "_err"},   32'(parse_err),  32'(m_err));
    check({tag, "_ovf"},   32'(overflow),   32'(m_ovf));
    check({tag, "_valid"}, 32'(disp_valid), 32'(exp_q.size() != 0));
    check({tag, "_rd"},    32'(rd_index),   m_rd);
    check({tag, "_hi"},    32'(disp_hi),    32'(e[7:4]));
    check({tag, "_lo"},    32'(disp_lo),    32'(e[3:0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_char(input logic [7:0] c);
    in_byte = c; in_en = 1'b1; wait_n(2);
    in_en = 1'b0; wait_n(2);
    model_char(c);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic send_done();
    in_done = 1'b1; wait_n(2);
    in_done = 1'b0; wait_n(2);
    model_done();
  endtask

  task automatic pulse_step();
    step = 1'b1; wait_n(2);
    step = 1'b0; wait_n(2);
    model_step();
  endtask

  task automatic do_clear();
    clear = 1'b1; wait_n(1);
    clear = 1'b0; wait_n(1);
    model_reset();
  endtask

  task automatic walk(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      pulse_step();
      check_state(tag);
    end
  endtask

  // ---------------- stimulus ----------------
  string hexs = "0123456789ABCDEFabcdef";
  string hexu = "0123456789ABCDEF";
  string seps = " \t\r\n,";
  string bads = "GZg.x#";

  initial begin
    logic [7:0] b;
    int r;

    wait_n(3);
    model_reset();
    check_state("reset");
    check("reset_state", 32'(dbg_state), 32'(S_HI));
    rstn = 1'b1;
    wait_n(1);

    // "3A 0f\n" with first-commit display latency
    send_char("3");
    in_byte = "A"; in_en = 1'b1;
    wait_n(1);
    check("t1_cnt_t1",   32'(byte_count), 1);
    check("t1_valid_t1", 32'(disp_valid), 0);
    wait_n(1);
    check("t1_valid_t2", 32'(disp_valid), 1);
    check("t1_hi_t2",    32'(disp_hi),    3);
    check("t1_lo_t2",    32'(disp_lo),    10);
    in_en = 1'b0; wait_n(2);
    model_char("A");
    send_str(" 0f\n");
    check_state("t1");
    check("t1_n", 32'(byte_count), 2);
    walk("t1_walk", 1);

    // "ABCD,5" then end of file
    do_clear();
    send_str("ABCD,5");
    send_done();
    check_state("t2");
    check("t2_n", 32'(byte_count), 3);
    walk("t2_walk", 2);

    // illegal character drops the pending nibble
    do_clear();
    send_str("1G2");
    send_done();
    check_state("t3");
    check("t3_err", 32'(parse_err), 1);
    check("t3_n",   32'(byte_count), 1);

    // three bytes, four steps: the last one is ignored
    do_clear();
    send_str("11 22 33");
    send_done();
    check_state("t4");
    walk("t4_walk", 4);
    check("t4_rd_end", 32'(rd_index), 2);

    // step edge coincident with a commit, then clear mid-stream
    do_clear();
    send_str("5A 7");
    in_byte = "8"; in_en = 1'b1; step = 1'b1;
    wait_n(2);
    in_en = 1'b0; step = 1'b0;
    wait_n(2);
    model_step();
    model_char("8");
    check_state("t5_same");
    send_char("9");
    do_clear();
    check_state("t5_clr");
    check("t5_clr_state", 32'(dbg_state), 32'(S_HI));
    send_str("C3");
    send_done();
    check_state("t5_new");

    // randomized text with interleaved steps
    do_clear();
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 11);
      if (r <= 6)       send_char(hexs[$urandom_range(0, 21)]);
      else if (r <= 8)  send_char(seps[$urandom_range(0, 4)]);
      else if (r == 9)  send_char(bads[$urandom_range(0, 5)]);
      else              pulse_step();
      check_state("rnd");
    end
    send_done();
    check_state("rnd_done");
    walk("rnd_walk", exp_q.size());

    // fill past capacity: 513 hex pairs
    do_clear();
    for (int i = 0; i < TB_DEPTH + 1; i++) begin
      b = 8'($urandom_range(0, 255));
      send_char(hexu[b[7:4]]);
      send_char(hexu[b[3:0]]);
    end
    check_state("ovf");
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_n",    32'(byte_count), TB_DEPTH);
    walk("ovf_walk", TB_DEPTH - 1);
    check("ovf_rd_end", 32'(rd_index), TB_DEPTH - 1);
    walk("ovf_wall", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
